// File: rtl/djs130_uart_tti_feeder.sv
// Serial 8N1 (or 8E1) receiver that buffers bytes in a FIFO and strobes them into the TTI.
// Latency: a byte reaches o_write 1 clk after it is pushed, provided the delivery gate is open.
// Backpressure: i_ready low and the inter-byte gap only stall delivery. A full FIFO drops new bytes and sets o_overrun.
//
// Ports: clk/rst (async, active-high), i_rxd serial in (idle high), i_ready consumer gate,
//        o_write/o_data byte strobe, o_fifo_count fill level, o_frame_err pulse, o_overrun sticky flag.
// Option: define DJS130_UART_PARITY_EN for 8E1 framing (even parity checked before push).
module djs130_uart_tti_feeder #(
    parameter int CLK_HZ     = 24000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_AW    = 4,
    parameter int GAP_CYCLES = 24000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_rxd,
    input  logic               i_ready,
    output logic               o_write,
    output logic [7:0]         o_data,
    output logic [FIFO_AW:0]   o_fifo_count,
    output logic               o_frame_err,
    output logic               o_overrun
);

    // Rounded divider for 16x oversampling.
    localparam int DIV   = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef DJS130_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    logic               rx_s1, rx_s2, rx_d;
    logic               fall;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    state_t             state;
    logic [3:0]         tcnt;
    logic [2:0]         bcnt;
    logic [7:0]         shreg;
    logic               push_vld;
    logic [7:0]         push_dat;
`ifdef DJS130_UART_PARITY_EN
    logic               par_bit;
`endif

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [GAP_W-1:0]   gap_cnt;
    logic               pop, push_ok;

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= i_rxd;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign fall = rx_d & ~rx_s2;

    // Free-running oversample divider, re-phased on the start edge so sampling lands mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if ((state == S_IDLE && fall) || div_cnt == DIV_W'(DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    // Receive FSM; tcnt counts oversample ticks within the current bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            bcnt        <= '0;
            shreg       <= '0;
            push_vld    <= 1'b0;
            push_dat    <= '0;
            o_frame_err <= 1'b0;
`ifdef DJS130_UART_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            push_vld    <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_START;
                        tcnt  <= '0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (tcnt == 4'd7) begin
                            // Mid start bit: high means it was only a glitch.
                            tcnt  <= '0;
                            bcnt  <= '0;
                            state <= rx_s2 ? S_IDLE : S_DATA;
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == 4'd15) begin
                            shreg <= {rx_s2, shreg[7:1]};
                            bcnt  <= bcnt + 3'd1;
                            if (bcnt == 3'd7) begin
`ifdef DJS130_UART_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end
                    end
                end
`ifdef DJS130_UART_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == 4'd15) begin
                            par_bit <= rx_s2;
                            state   <= S_STOP;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == 4'd15) begin
                            if (!rx_s2) begin
                                // Line held low through stop: wait for it to release.
                                o_frame_err <= 1'b1;
                                state       <= S_BREAK;
`ifdef DJS130_UART_PARITY_EN
                            end else if (^{shreg, par_bit}) begin
                                o_frame_err <= 1'b1;
                                state       <= S_IDLE;
`endif
                            end else begin
                                push_vld <= 1'b1;
                                push_dat <= shreg;
                                state    <= S_IDLE;
                            end
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s2) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pop is evaluated first, so a full FIFO being popped still takes the push.
    assign pop     = (count != '0) && (gap_cnt == '0) && i_ready;
    assign push_ok = push_vld && ((count != (FIFO_AW + 1)'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            gap_cnt   <= '0;
            o_write   <= 1'b0;
            o_data    <= 8'h00;
            o_overrun <= 1'b0;
        end else begin
            o_write <= pop;
            if (pop) begin
                o_data  <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + FIFO_AW'(1);
                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (push_vld && !push_ok) begin
                o_overrun <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign o_fifo_count = count;

endmodule
